// File: rtl/divisor_pkg.sv
// divisor_pkg: shared FSM state type and default operand width for the restoring divider
package divisor_pkg;
  localparam int DIV_WIDTH_DEFAULT = 8;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;
endpackage

// File: rtl/divisor_restoring_n_if.sv
// divisor_restoring_n_if: divider request/result bundle; master drives start/signed_mode/A_in/B_in, slave drives Q/R/done/busy/div_by_zero
interface divisor_restoring_n_if import divisor_pkg::*; #(parameter int WIDTH = DIV_WIDTH_DEFAULT);
  logic start, signed_mode, done, busy, div_by_zero;
  logic [WIDTH-1:0] A_in, B_in, Q, R;
  modport master (output start, signed_mode, A_in, B_in, input Q, R, done, busy, div_by_zero);
  modport slave (input start, signed_mode, A_in, B_in, output Q, R, done, busy, div_by_zero);
endinterface

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring step; shifts {rem,quo} left, trial-subtracts div, keeps or restores; in rem/quo/div, out rem_n/quo_n
module div_restore_step #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);
  logic [WIDTH:0] sh;
  logic ge;
  always_comb begin
    sh = {rem, quo[WIDTH-1]};
    ge = sh >= {1'b0, div};
    rem_n = ge ? sh[WIDTH-1:0] - div : sh[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], ge};
  end
endmodule

// File: rtl/divisor_restoring_n.sv
// divisor_restoring_n: multi-cycle signed/unsigned restoring divider; clk, async rst, bus (slave: start/operands in, Q/R/done/busy/div_by_zero out)
module divisor_restoring_n import divisor_pkg::*; #(parameter int WIDTH = DIV_WIDTH_DEFAULT) (
  input logic clk,
  input logic rst,
  divisor_restoring_n_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  div_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dv, rem_s, quo_s, a_mag, b_mag;
  logic a_neg, b_neg, neg_q, neg_r, dz, b_nz;
  always_comb begin
    a_neg = bus.signed_mode & bus.A_in[WIDTH-1];
    b_neg = bus.signed_mode & bus.B_in[WIDTH-1];
    a_mag = a_neg ? -bus.A_in : bus.A_in;
    b_mag = b_neg ? -bus.B_in : bus.B_in;
    b_nz = |bus.B_in;
  end
  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem), .quo(quo), .div(dv), .rem_n(rem_s), .quo_n(quo_s)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (bus.start ? (b_nz ? RUN : FIX) : IDLE)
            : state == RUN  ? (cnt == '0 ? FIX : RUN)
            : state == FIX  ? (cnt == '0 ? DONE : FIX)
            : IDLE;
  end
  always_comb begin
    bus.busy = state != IDLE;
    bus.done = state == DONE;
  end
  // FIX spends two cycles: the first applies sign/zero-divisor correction in place, the second publishes it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dv <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      bus.Q <= '0;
      bus.R <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          dz <= ~b_nz;
          dv <= b_mag;
          rem <= '0;
          quo <= b_nz ? a_mag : bus.A_in;
          cnt <= b_nz ? CW'(WIDTH-1) : CW'(1);
        end
        RUN: begin
          rem <= rem_s;
          quo <= quo_s;
          cnt <= cnt == '0 ? CW'(1) : cnt - 1'b1;
        end
        FIX: if (cnt != '0) begin
          quo <= dz ? '1 : neg_q ? -quo : quo;
          rem <= dz ? quo : neg_r ? -rem : rem;
          cnt <= cnt - 1'b1;
        end else begin
          bus.Q <= quo;
          bus.R <= rem;
          bus.div_by_zero <= dz;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_divisor_restoring_n.sv
// tb_divisor_restoring_n: directed and corner-weighted random checks of the restoring divider at WIDTH 4, 8 and 16
module tb_divisor_restoring_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  divisor_restoring_n_if #(.WIDTH(4)) i4 ();
  divisor_restoring_n_if #(.WIDTH(8)) i8 ();
  divisor_restoring_n_if #(.WIDTH(16)) i16 ();
  divisor_restoring_n #(.WIDTH(4)) d4 (.clk(clk), .rst(rst), .bus(i4));
  divisor_restoring_n #(.WIDTH(8)) d8 (.clk(clk), .rst(rst), .bus(i8));
  divisor_restoring_n #(.WIDTH(16)) d16 (.clk(clk), .rst(rst), .bus(i16));
  task automatic set_in(input int w, input logic st, input logic sm, input logic [31:0] a, input logic [31:0] b);
    case (w)
      4: begin i4.start = st; i4.signed_mode = sm; i4.A_in = a[3:0]; i4.B_in = b[3:0]; end
      16: begin i16.start = st; i16.signed_mode = sm; i16.A_in = a[15:0]; i16.B_in = b[15:0]; end
      default: begin i8.start = st; i8.signed_mode = sm; i8.A_in = a[7:0]; i8.B_in = b[7:0]; end
    endcase
  endtask
  task automatic get_out(input int w, output logic [31:0] q, output logic [31:0] r, output logic dn, output logic bs, output logic dz);
    case (w)
      4: begin q = 32'(i4.Q); r = 32'(i4.R); dn = i4.done; bs = i4.busy; dz = i4.div_by_zero; end
      16: begin q = 32'(i16.Q); r = 32'(i16.R); dn = i16.done; bs = i16.busy; dz = i16.div_by_zero; end
      default: begin q = 32'(i8.Q); r = 32'(i8.R); dn = i8.done; bs = i8.busy; dz = i8.div_by_zero; end
    endcase
  endtask
  task automatic launch(input int w, input logic sm, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    set_in(w, 1'b1, sm, a, b);
    @(negedge clk);
    set_in(w, 1'b0, sm, a, b);
  endtask
  task automatic wait_done(input int w, input int lat0, output int lat, output logic [31:0] q, output logic [31:0] r, output logic dz);
    logic dn, bs;
    lat = lat0;
    get_out(w, q, r, dn, bs, dz);
    while (!dn && lat < 200) begin
      @(negedge clk);
      lat++;
      get_out(w, q, r, dn, bs, dz);
    end
    if (!dn) lat = -1;
  endtask
  task automatic run_op(input int w, input logic sm, input logic [31:0] a, input logic [31:0] b, output int lat, output logic [31:0] q, output logic [31:0] r, output logic dz);
    launch(w, sm, a, b);
    wait_done(w, 0, lat, q, r, dz);
  endtask
  function automatic void ref_div(input int w, input logic sm, input logic [31:0] a, input logic [31:0] b, output logic [31:0] q, output logic [31:0] r, output logic dz);
    logic [31:0] m;
    longint sa, sb;
    m = (32'd1 << w) - 32'd1;
    dz = 1'b0;
    if (b == 0) begin
      q = m; r = a; dz = 1'b1;
    end else if (!sm) begin
      q = a / b; r = a % b;
    end else begin
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      q = 32'(sa / sb) & m;
      r = 32'(sa % sb) & m;
    end
  endfunction
  task automatic test_reset();
    set_in(4, 0, 0, 0, 0);
    set_in(8, 0, 0, 0, 0);
    set_in(16, 0, 0, 0, 0);
    #12;
    checks++; if (i8.Q !== 8'h00) begin errors++; $display("FAIL reset_q got %0h want 0", i8.Q); end
    checks++; if (i8.R !== 8'h00) begin errors++; $display("FAIL reset_r got %0h want 0", i8.R); end
    checks++; if (i8.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", i8.done); end
    checks++; if (i8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", i8.busy); end
    checks++; if (i8.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", i8.div_by_zero); end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_basic();
    int lat;
    logic [31:0] q, r;
    logic dz;
    launch(8, 0, 7, 2);
    checks++; if (i8.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start got %b want 1", i8.busy); end
    wait_done(8, 0, lat, q, r, dz);
    checks++; if (q !== 32'd3) begin errors++; $display("FAIL basic_q got %0d want 3", q); end
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL basic_r got %0d want 1", r); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL basic_dz got %b want 0", dz); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL basic_latency got %0d want 10", lat); end
    checks++; if (i8.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done got %b want 1", i8.busy); end
    @(negedge clk);
    checks++; if (i8.done !== 1'b0 || i8.busy !== 1'b0) begin errors++; $display("FAIL basic_after_done done=%b busy=%b want 0 0", i8.done, i8.busy); end
  endtask
  task automatic test_unsigned();
    logic [31:0] va [4] = '{50, 99, 120, 255};
    logic [31:0] vb [4] = '{7, 5, 10, 1};
    logic [31:0] eq [4] = '{7, 19, 12, 255};
    logic [31:0] er [4] = '{1, 4, 0, 0};
    int lat;
    logic [31:0] q, r;
    logic dz;
    for (int i = 0; i < 4; i++) begin
      run_op(8, 0, va[i], vb[i], lat, q, r, dz);
      checks++;
      if (q !== eq[i] || r !== er[i] || dz !== 1'b0 || lat !== 10) begin
        errors++;
        $display("FAIL unsigned_%0d/%0d got q=%0d r=%0d dz=%b lat=%0d want q=%0d r=%0d dz=0 lat=10", va[i], vb[i], q, r, dz, lat, eq[i], er[i]);
      end
    end
  endtask
  task automatic test_signed();
    logic [31:0] va [4] = '{32'hF9, 32'h07, 32'h80, 32'hF9};
    logic [31:0] vb [4] = '{32'h02, 32'hFE, 32'hFF, 32'hFE};
    logic [31:0] eq [4] = '{32'hFD, 32'hFD, 32'h80, 32'h03};
    logic [31:0] er [4] = '{32'hFF, 32'h01, 32'h00, 32'hFF};
    int lat;
    logic [31:0] q, r;
    logic dz;
    for (int i = 0; i < 4; i++) begin
      run_op(8, 1, va[i], vb[i], lat, q, r, dz);
      checks++;
      if (q !== eq[i] || r !== er[i] || dz !== 1'b0 || lat !== 10) begin
        errors++;
        $display("FAIL signed_%0h/%0h got q=%0h r=%0h dz=%b lat=%0d want q=%0h r=%0h dz=0 lat=10", va[i], vb[i], q, r, dz, lat, eq[i], er[i]);
      end
    end
  endtask
  task automatic test_div_zero();
    logic [31:0] va [3] = '{120, 120, 32'hF9};
    logic sm [3] = '{1'b0, 1'b1, 1'b1};
    int lat;
    logic [31:0] q, r;
    logic dz;
    for (int i = 0; i < 3; i++) begin
      run_op(8, sm[i], va[i], 0, lat, q, r, dz);
      checks++;
      if (q !== 32'hFF || r !== va[i] || dz !== 1'b1 || lat !== 2) begin
        errors++;
        $display("FAIL divzero_%0h_sm%0b got q=%0h r=%0h dz=%b lat=%0d want q=ff r=%0h dz=1 lat=2", va[i], sm[i], q, r, dz, lat, va[i]);
      end
    end
    run_op(8, 0, 120, 10, lat, q, r, dz);
    checks++;
    if (q !== 32'd12 || r !== 32'd0 || dz !== 1'b0 || lat !== 10) begin
      errors++;
      $display("FAIL divzero_clear got q=%0d r=%0d dz=%b lat=%0d want q=12 r=0 dz=0 lat=10", q, r, dz, lat);
    end
  endtask
  task automatic test_hold();
    int lat;
    logic [31:0] q, r;
    logic dz;
    repeat (5) @(negedge clk);
    checks++;
    if (i8.Q !== 8'd12 || i8.R !== 8'd0 || i8.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL hold got q=%0d r=%0d dz=%b want q=12 r=0 dz=0", i8.Q, i8.R, i8.div_by_zero);
    end
    run_op(8, 0, 7, 2, lat, q, r, dz);
    set_in(8, 1, 0, 99, 5);
    @(negedge clk);
    set_in(8, 0, 0, 99, 5);
    checks++; if (i8.busy !== 1'b0) begin errors++; $display("FAIL start_in_done busy got %b want 0", i8.busy); end
    repeat (12) @(negedge clk);
    checks++;
    if (i8.Q !== 8'd3 || i8.R !== 8'd1 || i8.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done_result got q=%0d r=%0d busy=%b want q=3 r=1 busy=0", i8.Q, i8.R, i8.busy);
    end
  endtask
  task automatic test_busy_ignore();
    int lat;
    logic [31:0] q, r;
    logic dz;
    launch(8, 0, 50, 7);
    repeat (3) @(negedge clk);
    set_in(8, 1, 1, 99, 5);
    @(negedge clk);
    set_in(8, 0, 1, 120, 10);
    wait_done(8, 4, lat, q, r, dz);
    checks++;
    if (q !== 32'd7 || r !== 32'd1 || dz !== 1'b0 || lat !== 10) begin
      errors++;
      $display("FAIL busy_ignore got q=%0d r=%0d dz=%b lat=%0d want q=7 r=1 dz=0 lat=10", q, r, dz, lat);
    end
  endtask
  task automatic test_reset_mid();
    int lat;
    int seen;
    logic [31:0] q, r;
    logic dz;
    run_op(8, 0, 120, 0, lat, q, r, dz);
    launch(8, 0, 99, 5);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (i8.Q !== 8'd0 || i8.R !== 8'd0 || i8.div_by_zero !== 1'b0 || i8.busy !== 1'b0 || i8.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got q=%0h r=%0h dz=%b busy=%b done=%b want all 0", i8.Q, i8.R, i8.div_by_zero, i8.busy, i8.done);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i8.done === 1'b1 || i8.busy === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_done got %0d active cycles want 0", seen); end
    run_op(8, 0, 99, 5, lat, q, r, dz);
    checks++;
    if (q !== 32'd19 || r !== 32'd4 || dz !== 1'b0 || lat !== 10) begin
      errors++;
      $display("FAIL reset_mid_after got q=%0d r=%0d dz=%b lat=%0d want q=19 r=4 dz=0 lat=10", q, r, dz, lat);
    end
  endtask
  task automatic test_regression();
    int ws [3] = '{4, 8, 16};
    int w, lat, elat;
    logic [31:0] m, mn, a, b, q, r, eq, er;
    logic dz, edz;
    for (int k = 0; k < 3; k++) begin
      w = ws[k];
      m = (32'd1 << w) - 32'd1;
      mn = 32'd1 << (w - 1);
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < 30; i++) begin
          case (i)
            0: begin a = mn; b = m; end
            1: begin a = m; b = 1; end
            2: begin a = 0; b = m; end
            3: begin a = m; b = m; end
            4: begin a = mn; b = 1; end
            default: begin
              case ($urandom_range(0, 4))
                0: a = 0;
                1: a = 1;
                2: a = m;
                3: a = mn;
                default: a = $urandom & m;
              endcase
              case ($urandom_range(0, 5))
                0: b = 0;
                1: b = 1;
                2: b = m;
                3: b = mn;
                default: b = $urandom & m;
              endcase
            end
          endcase
          ref_div(w, s[0], a, b, eq, er, edz);
          elat = b == 0 ? 2 : w + 2;
          run_op(w, s[0], a, b, lat, q, r, dz);
          checks++;
          if (q !== eq || r !== er || dz !== edz || lat !== elat) begin
            errors++;
            $display("FAIL regress_w%0d_sm%0d %0h/%0h got q=%0h r=%0h dz=%b lat=%0d want q=%0h r=%0h dz=%b lat=%0d", w, s, a, b, q, r, dz, lat, eq, er, edz, elat);
          end
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_hold();
    test_busy_ignore();
    test_reset_mid();
    test_regression();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/divisor_restoring_n.md
DIVISOR_RESTORING_N -- requirements
Module: divisor_restoring_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits, legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a division; sampled only when busy=0.
REQ-005 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port A_in  input  WIDTH  dividend; sampled with start.
REQ-007 SHALL have port B_in  input  WIDTH  divisor; sampled with start.
REQ-008 SHALL have port Q  output  WIDTH  quotient, registered.
REQ-009 SHALL have port R  output  WIDTH  remainder, registered.
REQ-010 SHALL have port done  output  1  one-cycle pulse when Q/R are valid.
REQ-011 SHALL have port busy  output  1  high from accepted start until the done cycle inclusive.
REQ-012 SHALL have port div_by_zero  output  1  flag, updated with Q/R; 1 when the sampled B_in was zero.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-014 IDLE + start=1 at edge k SHALL capture signed_mode, sign flags and magnitudes of A_in/B_in, load iteration counter WIDTH-1, go RUN (B≠0) or FIX (B=0).
REQ-015 RUN SHALL perform one restoring step per cycle: shift {rem,quo} left 1, trial-subtract divisor from rem (WIDTH+1-bit), keep result and set quotient bit 1 if non-negative, else restore and set 0.
REQ-016 RUN SHALL last exactly WIDTH cycles, then go FIX.
REQ-017 FIX SHALL register Q, R, div_by_zero, go DONE; DONE SHALL assert done=1 for one cycle, then go IDLE.
REQ-018 Latency SHALL be fixed: done high in the cycle following edge k+WIDTH+2 for B≠0; following edge k+2 for B=0.
REQ-019 Signed mode SHALL truncate toward zero: Q negated when operand signs differ; R takes the sign of the dividend.
REQ-020 Signed MIN/-1 SHALL yield Q=MIN (e.g. 0x80 for WIDTH=8), R=0, no flag.
REQ-021 B=0 SHALL yield Q=all ones, R=A_in as sampled (unmodified), div_by_zero=1, in both modes.
REQ-022 start while busy=1 SHALL be ignored; operands changing during busy SHALL have no effect.
REQ-023 start=1 in the DONE cycle SHALL be ignored; a new start is accepted from IDLE only, so back-to-back ops are spaced by ≥1 idle cycle.
REQ-024 Q, R, div_by_zero SHALL hold their values from FIX until the next FIX or reset.
REQ-025 busy SHALL be 0 in IDLE, 1 in RUN/FIX/DONE.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, Q=0, R=0, done=0, busy=0, div_by_zero=0, counter and datapath registers 0.
REQ-027 Reset mid-operation SHALL abort the division with no done pulse; first start after rst deasserts SHALL behave normally.

Structure
REQ-028 Shared package divisor_pkg SHALL hold the FSM state enum typedef and DIV_WIDTH_DEFAULT=8.
REQ-029 One sub-module div_restore_step (combinational, WIDTH-parametrised, one shift/subtract/restore step) SHALL be instantiated once in RUN datapath.

Verification
REQ-030 WIDTH=8, unsigned, A=7, B=2, start at edge k -> Q=3, R=1, div_by_zero=0, done pulse exactly after edge k+10, busy high k..done cycle.
REQ-031 Unsigned sweep 50/7, 99/5, 120/10, 255/1 -> Q/R = 7/1, 19/4, 12/0, 255/0.
REQ-032 Signed: -7/2 -> Q=0xFD (-3), R=0xFF (-1); 7/-2 -> Q=0xFD, R=0x01; -128/-1 -> Q=0x80, R=0.
REQ-033 Divide by zero: A=120, B=0, either mode -> Q=0xFF, R=120, div_by_zero=1, done after edge k+2; next 120/10 clears flag.
REQ-034 start pulsed and operands changed during RUN -> ignored, original result delivered; rst asserted mid-RUN -> outputs 0, no done, following 99/5 correct.
REQ-035 Random regression WIDTH=4, 8, 16 in both modes against a reference model, including all-ones, MIN, 0 and 1 operands.
